// File: rtl/yapay_zeka_hizlandiricisi_pkg.sv
// Shared YZH command codes and sequencer state encoding.
package yapay_zeka_hizlandiricisi_pkg;

  localparam logic [2:0] YZH_NOP   = 3'd0;
  localparam logic [2:0] YZH_LD_W  = 3'd1;
  localparam logic [2:0] YZH_CLR_W = 3'd2;
  localparam logic [2:0] YZH_LD_X  = 3'd3;
  localparam logic [2:0] YZH_CLR_X = 3'd4;
  localparam logic [2:0] YZH_RUN   = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } durum_t;

endpackage

// File: rtl/yzh_tampon.sv
// Operand buffer: 1- or 2-word write with saturating fill count, clear, and
// combinational read by index. Contents are not reset; only the count is.
module yzh_tampon #(
  parameter int GENISLIK = 32,
  parameter int DERINLIK = 32,
  parameter int SW       = $clog2(DERINLIK + 1),
  parameter int AW       = $clog2(DERINLIK)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                yaz,
  input  logic                ikinci,
  input  logic [GENISLIK-1:0] veri1,
  input  logic [GENISLIK-1:0] veri2,
  input  logic                temizle,
  input  logic [AW-1:0]       okuma_idx,
  output logic [GENISLIK-1:0] oku,
  output logic [SW-1:0]       sayi
);

  localparam logic [SW:0]   TAVAN   = (SW + 1)'(DERINLIK);
  localparam logic [SW-1:0] DERIN_S = SW'(DERINLIK);

  logic [GENISLIK-1:0] mem [DERINLIK];
  logic [SW:0]         sayi_art;
  logic [SW-1:0]       idx1;

  assign sayi_art = {1'b0, sayi} + {{(SW - 1){1'b0}}, ikinci, ~ikinci};
  assign idx1     = sayi + SW'(1);
  assign oku      = mem[okuma_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sayi <= '0;
    end else if (temizle) begin
      sayi <= '0;
    end else if (yaz) begin
      sayi <= (sayi_art > TAVAN) ? TAVAN[SW-1:0] : sayi_art[SW-1:0];
    end
  end

  // Words landing at or past the end are silently dropped.
  always_ff @(posedge clk) begin
    if (yaz && !temizle) begin
      if (sayi < DERIN_S) mem[sayi[AW-1:0]] <= veri1;
      if (ikinci && (idx1 < DERIN_S)) mem[idx1[AW-1:0]] <= veri2;
    end
  end

endmodule

// File: rtl/yapay_zeka_hizlandiricisi.sv
// YZH dot-product sequencer: loads W/X buffers and, on RUN, clears the external
// MAC then streams min(|W|,|X|) operand pairs; a stall freezes everything.
module yapay_zeka_hizlandiricisi
  import yapay_zeka_hizlandiricisi_pkg::*;
#(
  parameter int VERI_GENISLIK = 32,
  parameter int BUF_DERINLIK  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ddb_durdur_i,
  input  logic [2:0]               kontrol_i,
  input  logic                     basla_i,
  input  logic                     rs2_en_i,
  input  logic [VERI_GENISLIK-1:0] deger1_i,
  input  logic [VERI_GENISLIK-1:0] deger2_i,
  output logic                     carpma_rst_o,
  output logic                     bitti_o,
  output logic [VERI_GENISLIK-1:0] carp_deger1_o,
  output logic [VERI_GENISLIK-1:0] carp_deger2_o
);

  localparam int SW = $clog2(BUF_DERINLIK + 1);
  localparam int AW = $clog2(BUF_DERINLIK);

  durum_t                   durum;
  logic [SW-1:0]            idx;
  logic [SW-1:0]            sayi_w;
  logic [SW-1:0]            sayi_x;
  logic [SW-1:0]            n;
  logic [VERI_GENISLIK-1:0] oku_w;
  logic [VERI_GENISLIK-1:0] oku_x;
  logic                     kabul;

  assign kabul = (durum == IDLE) && basla_i && !ddb_durdur_i;
  assign n     = (sayi_w < sayi_x) ? sayi_w : sayi_x;

  yzh_tampon #(.GENISLIK(VERI_GENISLIK), .DERINLIK(BUF_DERINLIK)) u_w (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .yaz       (kabul && (kontrol_i == YZH_LD_W)),
    .ikinci    (rs2_en_i),
    .veri1     (deger1_i),
    .veri2     (deger2_i),
    .temizle   (kabul && (kontrol_i == YZH_CLR_W)),
    .okuma_idx (idx[AW-1:0]),
    .oku       (oku_w),
    .sayi      (sayi_w)
  );

  yzh_tampon #(.GENISLIK(VERI_GENISLIK), .DERINLIK(BUF_DERINLIK)) u_x (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .yaz       (kabul && (kontrol_i == YZH_LD_X)),
    .ikinci    (rs2_en_i),
    .veri1     (deger1_i),
    .veri2     (deger2_i),
    .temizle   (kabul && (kontrol_i == YZH_CLR_X)),
    .okuma_idx (idx[AW-1:0]),
    .oku       (oku_x),
    .sayi      (sayi_x)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum         <= IDLE;
      idx           <= '0;
      carpma_rst_o  <= 1'b0;
      bitti_o       <= 1'b0;
      carp_deger1_o <= '0;
      carp_deger2_o <= '0;
    end else if (!ddb_durdur_i) begin
      case (durum)
        IDLE: begin
          if (basla_i) begin
            if (kontrol_i == YZH_RUN) begin
              durum        <= CLEAR;
              carpma_rst_o <= 1'b1;
              idx          <= '0;
            end else begin
              durum   <= DONE;
              bitti_o <= 1'b1;
            end
          end
        end
        // CLEAR fetches pair 0 so STREAM cycle i shows W[i]/X[i].
        CLEAR, STREAM: begin
          carpma_rst_o <= 1'b0;
          if (idx == n) begin
            durum         <= DONE;
            bitti_o       <= 1'b1;
            carp_deger1_o <= '0;
            carp_deger2_o <= '0;
          end else begin
            durum         <= STREAM;
            carp_deger1_o <= oku_w;
            carp_deger2_o <= oku_x;
            idx           <= idx + SW'(1);
          end
        end
        DONE: begin
          bitti_o <= 1'b0;
          durum   <= IDLE;
        end
        default: durum <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yapay_zeka_hizlandiricisi.sv
// Randomized bench for the YZH sequencer against a queue-based buffer model.
module tb_yapay_zeka_hizlandiricisi;

  localparam int W = 32;
  localparam int D = 32;

  logic         clk_i;
  logic         rst_i;
  logic         ddb_durdur_i;
  logic [2:0]   kontrol_i;
  logic         basla_i;
  logic         rs2_en_i;
  logic [W-1:0] deger1_i;
  logic [W-1:0] deger2_i;
  logic         carpma_rst_o;
  logic         bitti_o;
  logic [W-1:0] carp_deger1_o;
  logic [W-1:0] carp_deger2_o;

  typedef logic [2*W+1:0] obs_t;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic [W-1:0] wm[$];
  logic [W-1:0] xm[$];

  yapay_zeka_hizlandiricisi #(.VERI_GENISLIK(W), .BUF_DERINLIK(D)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ddb_durdur_i  (ddb_durdur_i),
    .kontrol_i     (kontrol_i),
    .basla_i       (basla_i),
    .rs2_en_i      (rs2_en_i),
    .deger1_i      (deger1_i),
    .deger2_i      (deger2_i),
    .carpma_rst_o  (carpma_rst_o),
    .bitti_o       (bitti_o),
    .carp_deger1_o (carp_deger1_o),
    .carp_deger2_o (carp_deger2_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got hang, want completion)");
    $fatal(1, "watchdog");
  end

  function automatic obs_t obs();
    return {carpma_rst_o, bitti_o, carp_deger1_o, carp_deger2_o};
  endfunction

  // Issue one command and check every cycle until completion, optionally
  // stalling for 3 cycles after observation index stall_at.
  task automatic do_cmd(input logic [2:0] k, input logic r2, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall_at, input string nm);
    obs_t exp[$];
    int   n;
    case (k)
      3'd1: begin
        if (wm.size() < D) wm.push_back(a);
        if (r2 && wm.size() < D) wm.push_back(b);
      end
      3'd3: begin
        if (xm.size() < D) xm.push_back(a);
        if (r2 && xm.size() < D) xm.push_back(b);
      end
      3'd2: wm.delete();
      3'd4: xm.delete();
      default: ;
    endcase
    if (k == 3'd5) begin
      n = (wm.size() < xm.size()) ? wm.size() : xm.size();
      exp.push_back({1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}});
      for (int i = 0; i < n; i++) exp.push_back({1'b0, 1'b0, wm[i], xm[i]});
    end
    exp.push_back({1'b0, 1'b1, {W{1'b0}}, {W{1'b0}}});

    kontrol_i = k;
    rs2_en_i  = r2;
    deger1_i  = a;
    deger2_i  = b;
    basla_i   = 1'b1;
    for (int c = 0; c < exp.size(); c++) begin
      @(negedge clk_i);
      total_cnt++;
      if (obs() !== exp[c])
        $display("FAIL %s cycle %0d: got %h want %h", nm, c, obs(), exp[c]);
      else
        pass_cnt++;
      if (c == stall_at && c < exp.size() - 1) begin
        ddb_durdur_i = 1'b1;
        repeat (3) begin
          @(negedge clk_i);
          total_cnt++;
          if (obs() !== exp[c])
            $display("FAIL %s stall hold %0d: got %h want %h", nm, c, obs(), exp[c]);
          else
            pass_cnt++;
        end
        ddb_durdur_i = 1'b0;
      end
      if (exp[c][2*W]) basla_i = 1'b0;
    end
    basla_i = 1'b0;
    @(negedge clk_i);
    total_cnt++;
    if (obs() !== '0)
      $display("FAIL %s idle after: got %h want 0", nm, obs());
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; ddb_durdur_i = 1'b0; kontrol_i = 3'd0; basla_i = 1'b0;
    rs2_en_i = 1'b0; deger1_i = '0; deger2_i = '0;
    wm.delete(); xm.delete();
    repeat (2) @(negedge clk_i);
    total_cnt++;
    if (obs() !== '0) $display("FAIL reset_state: got %h want 0", obs());
    else pass_cnt++;
    rst_i = 1'b1;
    @(negedge clk_i);
    total_cnt++;
    if (obs() !== '0) $display("FAIL post_reset_idle: got %h want 0", obs());
    else pass_cnt++;
  endtask

  task automatic test_run_empty();
    do_cmd(3'd5, 1'b1, 32'd100, 32'd5, -1, "run_empty");
  endtask

  task automatic test_pair();
    do_cmd(3'd1, 1'b1, 32'd100, 32'd5, -1, "ldw_pair");
    do_cmd(3'd3, 1'b1, 32'd3, 32'd7, -1, "ldx_pair");
    do_cmd(3'd5, 1'b0, '0, '0, -1, "run_pair");
  endtask

  task automatic test_single();
    do_cmd(3'd2, 1'b0, '0, '0, -1, "clrw");
    do_cmd(3'd4, 1'b0, '0, '0, -1, "clrx");
    do_cmd(3'd1, 1'b0, 32'd2, 32'hdead, -1, "ldw_2");
    do_cmd(3'd1, 1'b0, 32'd4, 32'hbeef, -1, "ldw_4");
    do_cmd(3'd3, 1'b0, 32'd9, 32'hcafe, -1, "ldx_9");
    do_cmd(3'd5, 1'b0, '0, '0, -1, "run_single");
  endtask

  task automatic test_clear();
    do_cmd(3'd2, 1'b0, '0, '0, -1, "clrw_again");
    do_cmd(3'd5, 1'b0, '0, '0, -1, "run_after_clr");
    do_cmd(3'd1, 1'b0, 32'd1, '0, -1, "ldw_1");
    do_cmd(3'd5, 1'b0, '0, '0, -1, "run_reload");
  endtask

  task automatic test_saturate();
    do_cmd(3'd2, 1'b0, '0, '0, -1, "sat_clrw");
    do_cmd(3'd4, 1'b0, '0, '0, -1, "sat_clrx");
    for (int i = 0; i < 17; i++) do_cmd(3'd1, 1'b1, $urandom, $urandom, -1, "sat_ldw");
    for (int i = 0; i < 16; i++) do_cmd(3'd3, 1'b1, $urandom, $urandom, -1, "sat_ldx");
    do_cmd(3'd5, 1'b0, '0, '0, -1, "sat_run");
  endtask

  task automatic test_stall();
    ddb_durdur_i = 1'b1;
    kontrol_i = 3'd1; rs2_en_i = 1'b1; deger1_i = 32'h1111; deger2_i = 32'h2222;
    basla_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      total_cnt++;
      if (obs() !== '0) $display("FAIL stall_idle: got %h want 0", obs());
      else pass_cnt++;
    end
    basla_i = 1'b0;
    ddb_durdur_i = 1'b0;
    @(negedge clk_i);
    do_cmd(3'd5, 1'b0, '0, '0, 5, "stall_run");
  endtask

  task automatic test_random();
    logic [2:0] k;
    for (int i = 0; i < 40; i++) begin
      k = 3'($urandom_range(0, 7));
      do_cmd(k, 1'($urandom_range(0, 1)), $urandom, $urandom,
             int'($urandom_range(0, 4)), "random");
    end
  endtask

  task automatic test_reset_mid_run();
    do_cmd(3'd2, 1'b0, '0, '0, -1, "mr_clrw");
    do_cmd(3'd4, 1'b0, '0, '0, -1, "mr_clrx");
    for (int i = 0; i < 2; i++) begin
      do_cmd(3'd1, 1'b1, $urandom, $urandom, -1, "mr_ldw");
      do_cmd(3'd3, 1'b1, $urandom, $urandom, -1, "mr_ldx");
    end
    kontrol_i = 3'd5;
    basla_i   = 1'b1;
    repeat (3) @(negedge clk_i);
    total_cnt++;
    if (carp_deger1_o === '0) $display("FAIL mr_streaming: got %h want nonzero", carp_deger1_o);
    else pass_cnt++;
    rst_i = 1'b0;
    #1;
    total_cnt++;
    if (obs() !== '0) $display("FAIL mr_async_reset: got %h want 0", obs());
    else pass_cnt++;
    basla_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    wm.delete(); xm.delete();
    @(negedge clk_i);
    do_cmd(3'd5, 1'b0, '0, '0, -1, "mr_run_empty");
  endtask

  initial begin
    test_reset();
    test_run_empty();
    test_pair();
    test_single();
    test_clear();
    test_saturate();
    test_stall();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/yapay_zeka_hizlandiricisi.md
Name: yapay_zeka_hizlandiricisi

Overview:
- Convolution/dot-product accelerator behind the custom YZH instructions (LD_W, CLR_W, LD_X, CLR_X, RUN), driven from the core's execute stage.
- Holds a weight buffer W and an input buffer X.
- On RUN, streams element pairs W[i], X[i] to an external multiply-accumulate unit and signals completion to the pipeline.
- Accumulation and the final result live in that external unit; this block only sequences operands and clears the accumulator.

Parameters:
- VERI_GENISLIK, 32, width of every buffer entry and data port.
- BUF_DERINLIK, 32, number of entries in each of W and X.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-low reset.
- ddb_durdur_i  input  1  pipeline stall: when high, all state and outputs freeze.
- kontrol_i  input  3  command code (YZH_* constants).
- basla_i  input  1  command request; held high by the core until bitti_o.
- rs2_en_i  input  1  for LD_W/LD_X: deger2_i is also a valid operand.
- deger1_i  input  32  rs1 operand.
- deger2_i  input  32  rs2 operand.
- carpma_rst_o  output  1  clears the external accumulator.
- bitti_o  output  1  command complete, one cycle.
- carp_deger1_o  output  32  W operand to the multiplier.
- carp_deger2_o  output  32  X operand to the multiplier.

Behaviour:
- Reset (rst_i=0, async):
  - State IDLE; W and X counts 0; read index 0.
  - carpma_rst_o=0, bitti_o=0, carp_deger1_o=0, carp_deger2_o=0.
  - Buffer contents need not be cleared.
- Stall: while ddb_durdur_i=1, no state, count, index or buffer changes; outputs hold their values. The external MAC is gated by the same stall signal.
- Command acceptance: in IDLE, on a rising edge with basla_i=1 and ddb_durdur_i=0.
- kontrol_i values other than the five commands:
  - Complete as no-ops through DONE.
- LD_W:
  - W[cnt]<=deger1_i.
  - If rs2_en_i=1, also W[cnt+1]<=deger2_i.
  - cnt advances by 1 or 2.
  - Writes beyond BUF_DERINLIK are dropped; cnt saturates at BUF_DERINLIK.
  - Next state DONE.
- LD_X: identical to LD_W, on buffer X.
- CLR_W / CLR_X: that buffer's count <= 0; next state DONE.
- RUN: N = min(W count, X count). Sequence:
  - CLEAR, 1 cycle: carpma_rst_o=1, operands 0.
  - STREAM, N cycles: cycle i (0..N-1) drives carp_deger1_o=W[i], carp_deger2_o=X[i].
  - N=0: CLEAR goes directly to DONE.
  - DONE, 1 cycle.
  - Total latency from acceptance: N+2 cycles.
  - Buffer counts are not modified by RUN.
- Operand outputs are 0 in every state except STREAM, so the MAC adds zero outside STREAM.
- DONE: bitti_o=1 for exactly one unstalled cycle, then IDLE.
- Handshake: the core deasserts basla_i on the edge it samples bitti_o. A basla_i still high in IDLE is a new command.
- FSM states: IDLE, CLEAR, STREAM, DONE.
- Reset mid-RUN: immediate return to IDLE with all outputs 0; counts return to 0.

Decomposition:
- Shared package (tanimlamalar.vh) holds the command constants:
  - YZH_NOP=3'd0, YZH_LD_W=3'd1, YZH_CLR_W=3'd2, YZH_LD_X=3'd3, YZH_CLR_X=3'd4, YZH_RUN=3'd5.
  - It also holds the FSM state encodings.
- One sub-module is natural: yzh_tampon, one instance each for W and X. It is a parameterised buffer containing:
  - a write port of 1 or 2 words with a saturating count;
  - clear;
  - a combinational read by index.

Test Plan:
- Reset then RUN with deger1=100, deger2=5, basla=1 -> carpma_rst_o pulses next cycle. bitti_o the cycle after. Operands stay 0 (N=0).
- LD_W rs2_en=1 (100,5), LD_X rs2_en=1 (3,7), RUN -> CLEAR, then (100,3), then (5,7) on carp_deger1_o/2_o, then bitti_o. Total 4 cycles.
- LD_W rs2_en=0 with 2 then 4, LD_X 9 only, RUN -> N=1, one stream cycle (2,9). The extra W entry is ignored.
- CLR_W after loads, then RUN -> N=0 path. Reload W (1) -> stream uses W[0]=1.
- 17 LD_W with rs2_en=1 at BUF_DERINLIK=32 -> count saturates at 32. The last two writes are dropped and RUN streams 32 pairs (X full).
- ddb_durdur_i high for 3 cycles mid-STREAM -> operands held and index frozen; sequence resumes intact. rst_i low mid-RUN -> outputs 0 asynchronously.
